// File: rtl/mod_148_4_5_timer_bank_pkg.sv
// Shared definitions for the PLCA timer bank: channel state encoding,
// default durations of the commit / mii_clock / pending timers, and the
// terminal-count helper used at elaboration.
package mod_148_4_5_timer_bank_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } tmr_state_t;

    localparam int unsigned CLAUSE_148_COMMIT_NS    = 28800;
    localparam int unsigned CLAUSE_148_MII_CLOCK_NS = 0;
    localparam int unsigned CLAUSE_148_PENDING_NS   = 51200;

    // ch0 in the LSBs: {pending, mii_clock, commit}
    localparam logic [95:0] CLAUSE_148_DUR_NS = {
        32'(CLAUSE_148_PENDING_NS),
        32'(CLAUSE_148_MII_CLOCK_NS),
        32'(CLAUSE_148_COMMIT_NS)
    };

    // Number of clock edges that cover dur_ns, rounded up.
    function automatic int unsigned tc_calc(input int unsigned dur_ns,
                                            input int unsigned period_ns);
        longint unsigned sum;
        sum = longint'(dur_ns) + longint'(period_ns) - 64'd1;
        return int'(sum / longint'(period_ns));
    endfunction

endpackage

// File: rtl/mod_148_4_5_timer_bank_channel.sv
// One clock-counted timer with start/stop, single-shot or periodic reload,
// and a one-cycle expiry pulse. done/not_done decode the registered state.
module mod_148_timer_channel
    import mod_148_4_5_timer_bank_pkg::*;
#(
    parameter int unsigned TC       = 1,
    parameter int unsigned CNT_W    = 12,
    parameter logic        PERIODIC = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic start,
    input  logic stop,
    output logic done,
    output logic not_done,
    output logic expired
);

    if (64'(TC) > ((64'd1 << CNT_W) - 64'd1)) begin : g_tc_too_large
        $error("terminal count %0d does not fit in %0d bits", TC, CNT_W);
    end

    localparam logic [CNT_W-1:0] TC_C  = CNT_W'(TC);
    localparam logic [CNT_W-1:0] ONE_C = CNT_W'(1);

    tmr_state_t       state, state_nxt;
    logic [CNT_W-1:0] count, count_nxt;
    logic             expired_nxt;

    // State, counter and expiry pulse registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            count   <= '0;
            expired <= 1'b0;
        end else begin
            state   <= state_nxt;
            count   <= count_nxt;
            expired <= expired_nxt;
        end
    end

    // Next state: start beats stop, and a restart on the expiry edge
    // reloads the count without pulsing.
    always_comb begin
        state_nxt   = state;
        count_nxt   = count;
        expired_nxt = 1'b0;
        if (start) begin
            if (TC_C == '0) begin
                // zero duration: expire immediately; periodic keeps firing
                expired_nxt = 1'b1;
                count_nxt   = '0;
                state_nxt   = PERIODIC ? ST_RUN : ST_DONE;
            end else begin
                state_nxt = ST_RUN;
                count_nxt = TC_C;
            end
        end else if (stop) begin
            state_nxt = ST_IDLE;
            count_nxt = '0;
        end else if (state == ST_RUN) begin
            if (TC_C == '0) begin
                expired_nxt = 1'b1;
            end else if (count == ONE_C) begin
                expired_nxt = 1'b1;
                if (PERIODIC) begin
                    count_nxt = TC_C;
                end else begin
                    state_nxt = ST_DONE;
                    count_nxt = '0;
                end
            end else begin
                count_nxt = count - ONE_C;
            end
        end
    end

    assign done     = (state == ST_DONE);
    assign not_done = (state == ST_RUN);

endmodule

// File: rtl/mod_148_4_5_timer_bank.sv
// Bank of NUM_CH independent PLCA timers. Each channel's terminal count is
// derived from its slice of DUR_NS and the clock period at elaboration.
module mod_148_4_5_timer_bank
    import mod_148_4_5_timer_bank_pkg::*;
#(
    parameter int unsigned          NUM_CH        = 3,
    parameter int unsigned          CNT_W         = 12,
    parameter int unsigned          CLK_PERIOD_NS = 40,
    parameter logic [NUM_CH*32-1:0] DUR_NS        = CLAUSE_148_DUR_NS,
    parameter logic [NUM_CH-1:0]    PERIODIC      = '0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [NUM_CH-1:0] start_timer,
    input  logic [NUM_CH-1:0] stop_timer,
    output logic [NUM_CH-1:0] timer_done,
    output logic [NUM_CH-1:0] timer_not_done,
    output logic [NUM_CH-1:0] timer_expired
);

    if (NUM_CH < 1 || NUM_CH > 16) begin : g_bad_num_ch
        $error("NUM_CH must be 1..16, got %0d", NUM_CH);
    end
    if (CLK_PERIOD_NS == 0) begin : g_bad_period
        $error("CLK_PERIOD_NS must be non-zero");
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int unsigned TC_I = tc_calc(DUR_NS[i*32 +: 32], CLK_PERIOD_NS);

        mod_148_timer_channel #(
            .TC       (TC_I),
            .CNT_W    (CNT_W),
            .PERIODIC (PERIODIC[i])
        ) u_ch (
            .clk      (clk),
            .reset_n  (reset_n),
            .start    (start_timer[i]),
            .stop     (stop_timer[i]),
            .done     (timer_done[i]),
            .not_done (timer_not_done[i]),
            .expired  (timer_expired[i])
        );
    end

endmodule

// File: tb/tb_mod_148_4_5_timer_bank.sv
// Bench for the PLCA timer bank: a single-shot instance and a periodic
// instance share stimulus; a deadline-based reference model feeds an
// expected-value queue checked after every clock edge, plus directed
// checks at the timing points of interest.
module tb_mod_148_4_5_timer_bank;

    localparam int unsigned TC_M [3] = '{720, 0, 1280};
    localparam logic [2:0]  PER_P    = 3'b110;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [2:0] start_timer, stop_timer;
    logic [2:0] dn_d, nd_d, ex_d;
    logic [2:0] dn_p, nd_p, ex_p;
    logic [17:0] obs;

    int n_tests = 0;
    int n_fail  = 0;

    int          m_mode [2][3];
    longint      m_dl   [2][3];
    logic        m_exp  [2][3];
    longint      cyc;
    logic [17:0] exp_q [$];

    always #20 clk = ~clk;

    mod_148_4_5_timer_bank #(
        .NUM_CH(3), .CNT_W(12), .CLK_PERIOD_NS(40),
        .DUR_NS({32'd51200, 32'd0, 32'd28800}), .PERIODIC(3'b000)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .start_timer(start_timer), .stop_timer(stop_timer),
        .timer_done(dn_d), .timer_not_done(nd_d), .timer_expired(ex_d)
    );

    mod_148_4_5_timer_bank #(
        .NUM_CH(3), .CNT_W(12), .CLK_PERIOD_NS(40),
        .DUR_NS({32'd51200, 32'd0, 32'd28800}), .PERIODIC(PER_P)
    ) u_dut_per (
        .clk(clk), .reset_n(reset_n), .start_timer(start_timer), .stop_timer(stop_timer),
        .timer_done(dn_p), .timer_not_done(nd_p), .timer_expired(ex_p)
    );

    assign obs = {ex_p, nd_p, dn_p, ex_d, nd_d, dn_d};

    task automatic chk(input string tag, input logic [17:0] o, input logic [17:0] e);
        n_tests++;
        assert (o === e) else begin
            n_fail++;
            $display("FAIL %s: observed %0h required %0h", tag, o, e);
            $error("%s observed %0h expected %0h", tag, o, e);
        end
    endtask

    task automatic chk_bit(input string tag, input logic o, input logic e);
        chk(tag, {17'b0, o}, {17'b0, e});
    endtask

    task automatic model_reset();
        cyc = 0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
                m_mode[d][c] = 0;
                m_dl[d][c]   = 0;
                m_exp[d][c]  = 1'b0;
            end
    endtask

    // One clock edge of the reference: mode 0 idle, 1 running, 2 done.
    task automatic model_edge(input logic [2:0] st, input logic [2:0] sp);
        logic per;
        cyc++;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
                per = (d == 1) ? PER_P[c] : 1'b0;
                m_exp[d][c] = 1'b0;
                if (st[c]) begin
                    if (TC_M[c] == 0) begin
                        m_exp[d][c]  = 1'b1;
                        m_mode[d][c] = per ? 1 : 2;
                    end else begin
                        m_mode[d][c] = 1;
                        m_dl[d][c]   = cyc + longint'(TC_M[c]);
                    end
                end else if (sp[c]) begin
                    m_mode[d][c] = 0;
                end else if (m_mode[d][c] == 1) begin
                    if (TC_M[c] == 0) begin
                        m_exp[d][c] = 1'b1;
                    end else if (cyc == m_dl[d][c]) begin
                        m_exp[d][c] = 1'b1;
                        if (per) m_dl[d][c] = cyc + longint'(TC_M[c]);
                        else     m_mode[d][c] = 2;
                    end
                end
            end
    endtask

    function automatic logic [17:0] model_vec();
        logic [17:0] v;
        v = '0;
        for (int d = 0; d < 2; d++)
            for (int c = 0; c < 3; c++) begin
                v[d*9 + c]     = (m_mode[d][c] == 2);
                v[d*9 + 3 + c] = (m_mode[d][c] == 1);
                v[d*9 + 6 + c] = m_exp[d][c];
            end
        return v;
    endfunction

    task automatic step(input logic [2:0] st, input logic [2:0] sp);
        logic [17:0] e;
        start_timer = st;
        stop_timer  = sp;
        @(posedge clk);
        model_edge(st, sp);
        exp_q.push_back(model_vec());
        #1;
        e = exp_q.pop_front();
        chk("cycle", obs, e);
        chk("exclusive", {12'b0, dn_p & nd_p, dn_d & nd_d}, 18'd0);
        start_timer = '0;
        stop_timer  = '0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(3'b000, 3'b000);
    endtask

    initial begin
        reset_n     = 1'b0;
        start_timer = '0;
        stop_timer  = '0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", obs, 18'd0);
        @(negedge clk);
        reset_n = 1'b1;

        // 1: asynchronous reset in the middle of a run
        step(3'b101, 3'b000);
        idle(100);
        @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("async_reset", obs, 18'd0);
        model_reset();
        @(negedge clk);
        reset_n = 1'b1;
        idle(20);
        chk("quiet_after_reset", obs, 18'd0);

        // 2: ch0 single-shot, 720 edges
        step(3'b001, 3'b000);
        chk_bit("t2_nd_k", nd_d[0], 1'b1);
        idle(719);
        chk_bit("t2_nd_k719", nd_d[0], 1'b1);
        chk_bit("t2_dn_k719", dn_d[0], 1'b0);
        step(3'b000, 3'b000);
        chk_bit("t2_dn_k720", dn_d[0], 1'b1);
        chk_bit("t2_ex_k720", ex_d[0], 1'b1);
        step(3'b000, 3'b000);
        chk_bit("t2_ex_k721", ex_d[0], 1'b0);
        idle(1000);
        chk_bit("t2_dn_held", dn_d[0], 1'b1);

        // 3: ch1 zero duration
        step(3'b010, 3'b000);
        chk_bit("t3_dn", dn_d[1], 1'b1);
        chk_bit("t3_ex", ex_d[1], 1'b1);
        chk_bit("t3_nd", nd_d[1], 1'b0);
        chk_bit("t3_per_ex", ex_p[1], 1'b1);
        step(3'b000, 3'b000);
        chk_bit("t3_ex_next", ex_d[1], 1'b0);
        chk_bit("t3_per_ex_held", ex_p[1], 1'b1);

        // 4: ch2 stop, then start+stop on one edge
        step(3'b100, 3'b000);
        idle(499);
        step(3'b000, 3'b100);
        chk_bit("t4_stop_nd", nd_d[2], 1'b0);
        chk_bit("t4_stop_ex", ex_d[2], 1'b0);
        idle(99);
        step(3'b100, 3'b100);
        chk_bit("t4_startwins", nd_d[2], 1'b1);
        idle(1279);
        chk_bit("t4_nd_k1879", nd_d[2], 1'b1);
        step(3'b000, 3'b000);
        chk_bit("t4_dn_k1880", dn_d[2], 1'b1);
        chk_bit("t4_ex_k1880", ex_d[2], 1'b1);

        // 5: periodic ch2 fires every 1280 edges
        step(3'b000, 3'b111);
        step(3'b100, 3'b000);
        for (int r = 0; r < 3; r++) begin
            idle(1279);
            step(3'b000, 3'b000);
            chk_bit("t5_per_ex", ex_p[2], 1'b1);
            chk_bit("t5_per_dn", dn_p[2], 1'b0);
            chk_bit("t5_per_nd", nd_p[2], 1'b1);
        end

        // 6: restart ch0 one edge before expiry, and on the expiry edge
        step(3'b001, 3'b000);
        idle(718);
        step(3'b001, 3'b000);
        step(3'b000, 3'b000);
        chk_bit("t6_no_ex_k720", ex_d[0], 1'b0);
        chk_bit("t6_nd_k720", nd_d[0], 1'b1);
        idle(718);
        step(3'b000, 3'b000);
        chk_bit("t6_dn_k1439", dn_d[0], 1'b1);
        chk_bit("t6_ex_k1439", ex_d[0], 1'b1);
        step(3'b001, 3'b000);
        idle(719);
        step(3'b001, 3'b000);
        chk_bit("t6_restart_on_expiry_ex", ex_d[0], 1'b0);
        chk_bit("t6_restart_on_expiry_nd", nd_d[0], 1'b1);

        // random start/stop traffic against the model
        for (int i = 0; i < 4000; i++) begin
            logic [2:0] st, sp;
            for (int c = 0; c < 3; c++) begin
                st[c] = ($urandom_range(0, 99) == 0);
                sp[c] = ($urandom_range(0, 149) == 0);
            end
            step(st, sp);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
